// File: rtl/wide_alu_sequencer.sv
// wide_alu_sequencer
// Feeds one wide (WORDS x 32-bit) operation to a 32-bit combinational ALU,
// one limb per cycle, least-significant limb first. Carry/borrow is chained
// between limbs from the limb operands and the ALU result, and the wide
// result is returned over a valid/ready handshake.
module wide_alu_sequencer #(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  op_cin,
  input  logic [1:0]            op_ctrl,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic                  alu_cin,
  output logic [1:0]            alu_ctrl,
  input  logic [31:0]           alu_out,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [32*WORDS-1:0]   res_data,
  output logic                  res_cout
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  localparam logic [1:0] CTRL_ADD = 2'b00;
  localparam logic [1:0] CTRL_SUB = 2'b01;
  localparam logic [1:0] CTRL_OR  = 2'b10;
  localparam logic [1:0] CTRL_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // ADD and SUB chain a carry/borrow; the logical ops never do.
  function automatic logic is_arith(input logic [1:0] ctrl);
    return (ctrl == CTRL_ADD) || (ctrl == CTRL_SUB);
  endfunction

  // Carry/borrow out of one limb, derived from the limb operands and the
  // ALU result rather than an ALU carry output. For ADD a wrapped sum is
  // smaller than its operand; equality with carry-in means b was all ones.
  function automatic logic limb_carry(
    input logic [1:0]  ctrl,
    input logic [31:0] a_limb,
    input logic [31:0] b_limb,
    input logic [31:0] sum,
    input logic        carry_in
  );
    logic c;
    case (ctrl)
      CTRL_ADD: c = (sum < a_limb) || (carry_in && (sum == a_limb));
      CTRL_SUB: c = (a_limb < b_limb) || (carry_in && (a_limb == b_limb));
      CTRL_OR:  c = 1'b0;
      CTRL_AND: c = 1'b0;
      default:  c = 1'b0;
    endcase
    return c;
  endfunction

  state_t          state_r;
  state_t          next_state_s;
  logic            accept_s;
  logic            capture_s;
  logic            last_limb_s;

  logic [31:0]     a_r   [WORDS];
  logic [31:0]     b_r   [WORDS];
  logic [31:0]     res_r [WORDS];
  logic [1:0]      ctrl_r;
  logic            carry_r;
  logic [IDX_W-1:0] idx_r;
  logic            res_cout_r;

  logic [31:0]     a_limb_s;
  logic [31:0]     b_limb_s;
  logic            carry_next_s;

  // Handshake-ready only when idle, and never while reset is asserted.
  assign op_ready = (state_r == IDLE) && rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic plus the accept/capture strobes for the datapath.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    last_limb_s  = (idx_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (op_valid) begin
          accept_s     = 1'b1;
          next_state_s = EXEC;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: begin
        capture_s = 1'b1;
        if (last_limb_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = EXEC;
        end
      end
      DONE: begin
        if (res_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Current limb selection and the carry that leaves this limb.
  always_comb begin
    a_limb_s     = a_r[idx_r];
    b_limb_s     = b_r[idx_r];
    carry_next_s = limb_carry(ctrl_r, a_limb_s, b_limb_s, alu_out, carry_r);
  end

  // ALU drive: live limb operands in EXEC, all zero otherwise.
  always_comb begin
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_cin  = 1'b0;
    alu_ctrl = 2'b00;
    if (state_r == EXEC) begin
      alu_a    = a_limb_s;
      alu_b    = b_limb_s;
      alu_cin  = carry_r & is_arith(ctrl_r);
      alu_ctrl = ctrl_r;
    end else begin
      alu_a    = 32'd0;
      alu_b    = 32'd0;
      alu_cin  = 1'b0;
      alu_ctrl = 2'b00;
    end
  end

  // Operand capture on accept, limb-by-limb result capture in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        a_r[i]   <= 32'd0;
        b_r[i]   <= 32'd0;
        res_r[i] <= 32'd0;
      end
      ctrl_r     <= 2'b00;
      carry_r    <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      res_cout_r <= 1'b0;
    end else if (accept_s) begin
      for (int i = 0; i < WORDS; i++) begin
        a_r[i] <= op_a[32*i +: 32];
        b_r[i] <= op_b[32*i +: 32];
      end
      ctrl_r  <= op_ctrl;
      carry_r <= is_arith(op_ctrl) ? op_cin : 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else if (capture_s) begin
      res_r[idx_r] <= alu_out;
      carry_r      <= carry_next_s;
      if (last_limb_s) begin
        res_cout_r <= carry_next_s;
        idx_r      <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Result presentation: valid is the DONE state, data is the limb store.
  always_comb begin
    res_valid = (state_r == DONE);
    res_cout  = res_cout_r;
    res_data  = {(32*WORDS){1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      res_data[32*i +: 32] = res_r[i];
    end
  end

endmodule

// File: tb/tb_wide_alu_sequencer.sv
// Self-checking bench for wide_alu_sequencer (WORDS=2) with a behavioural
// 32-bit ALU attached to the alu_* port, a vector table and a result queue.
module tb_wide_alu_sequencer;

  localparam int W = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [63:0]     op_a = 64'd0;
  logic [63:0]     op_b = 64'd0;
  logic            op_cin = 1'b0;
  logic [1:0]      op_ctrl = 2'b00;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic            alu_cin;
  logic [1:0]      alu_ctrl;
  logic [31:0]     alu_out;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [63:0]     res_data;
  logic            res_cout;

  wide_alu_sequencer #(.WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_ctrl(op_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cout(res_cout)
  );

  always #5 clk = ~clk;

  // Behavioural 32-bit ALU stage.
  always_comb begin
    case (alu_ctrl)
      2'b00:   alu_out = alu_a + alu_b + {31'd0, alu_cin};
      2'b01:   alu_out = alu_a - alu_b - {31'd0, alu_cin};
      2'b10:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a & alu_b;
    endcase
  end

  typedef struct {
    logic [1:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] exp_data;
    logic        exp_cout;
    logic        exp_cin0;
    logic        exp_cin1;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        cout;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  logic cin_seen[8];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Offer an op, wait for acceptance, then follow EXEC until res_valid.
  task automatic send_op(input logic [1:0] ctrl, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic [63:0] exp_data, input logic exp_cout);
    exp_t e;
    int   cyc;
    e.data = exp_data;
    e.cout = exp_cout;
    sb.push_back(e);
    op_ctrl  = ctrl;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    op_valid = 1'b1;
    cyc = 0;
    while (!op_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("op_ready_wait", {63'd0, op_ready}, 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
    for (int i = 0; i < 8; i++) cin_seen[i] = 1'b0;
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      if (cyc < 8) cin_seen[cyc] = alu_cin;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(W));
  endtask

  // Complete the result handshake and compare against the queue head.
  task automatic take_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_data"}, res_data, e.data);
      check({tag, "_cout"}, {63'd0, res_cout}, {63'd0, e.cout});
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, res_valid}, 64'd0);
  endtask

  initial begin
    logic [64:0] wide;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic [1:0]  rctrl;

    vecs[0] = '{2'b00, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{2'b01, 64'h00000001_00000000, 64'h1, 1'b0, 64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{2'b01, 64'h0, 64'h1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 64'hF0F0F0F0_0000FFFF, 64'h0F0F0F0F_FFFF0000, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{2'b11, 64'hF0F0F0F0_0000FFFF, 64'h0F0F0F0F_FFFF0000, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b00, 64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0, 64'h22222222_22222211, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2'b01, 64'h5, 64'h5, 1'b1, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b1, 1'b1};

    // Reset state.
    #12;
    check("rst_op_ready", {63'd0, op_ready}, 64'd0);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_cout", {63'd0, res_cout}, 64'd0);
    check("rst_alu_a", {32'd0, alu_a}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int v = 0; v < 8; v++) begin
      send_op(vecs[v].ctrl, vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].exp_data, vecs[v].exp_cout);
      check($sformatf("v%0d_alu_cin0", v), {63'd0, cin_seen[0]}, {63'd0, vecs[v].exp_cin0});
      check($sformatf("v%0d_alu_cin1", v), {63'd0, cin_seen[1]}, {63'd0, vecs[v].exp_cin1});
      check($sformatf("v%0d_alu_idle", v), {30'd0, alu_ctrl, alu_a}, 64'd0);
      take_result($sformatf("v%0d", v));
    end

    // Random vectors against a 65-bit reference.
    for (int r = 0; r < 6; r++) begin
      ra    = {$urandom, $urandom};
      rb    = {$urandom, $urandom};
      rc    = 1'($urandom_range(0, 1));
      rctrl = 2'($urandom_range(0, 3));
      case (rctrl)
        2'b00:   wide = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
        2'b01:   wide = {1'b0, ra} - {1'b0, rb} - {64'd0, rc};
        2'b10:   wide = {1'b0, ra | rb};
        default: wide = {1'b0, ra & rb};
      endcase
      send_op(rctrl, ra, rb, rc, wide[63:0], wide[64]);
      take_result($sformatf("rnd%0d", r));
    end

    // Backpressure: new op offered while the result is held.
    send_op(2'b00, 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0);
    op_ctrl  = 2'b10;
    op_a     = 64'h00000000_000000F0;
    op_b     = 64'h0000000F_0000000F;
    op_cin   = 1'b0;
    op_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid", c), {63'd0, res_valid}, 64'd1);
      check($sformatf("bp%0d_data", c), res_data, 64'h00000001_00000000);
      check($sformatf("bp%0d_op_ready", c), {63'd0, op_ready}, 64'd0);
    end
    take_result("bp_first");
    check("bp_idle_ready", {63'd0, op_ready}, 64'd1);
    send_op(2'b10, 64'h00000000_000000F0, 64'h0000000F_0000000F, 1'b0, 64'h0000000F_000000FF, 1'b0);
    take_result("bp_second");

    // Reset during EXEC limb 0 of an ADD.
    op_ctrl  = 2'b00;
    op_a     = 64'h11111111_22222222;
    op_b     = 64'h33333333_44444444;
    op_cin   = 1'b1;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("mid_alu_a", {32'd0, alu_a}, 64'h22222222);
    check("mid_alu_cin", {63'd0, alu_cin}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mr_res_valid", {63'd0, res_valid}, 64'd0);
    check("mr_res_data", res_data, 64'd0);
    check("mr_alu", {alu_a, alu_b}, 64'd0);
    check("mr_alu_ctl", {62'd0, alu_cin, 1'b0}, 64'd0);
    check("mr_op_ready", {63'd0, op_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mr_after_valid", {63'd0, res_valid}, 64'd0);
    send_op(2'b00, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0);
    take_result("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wide_alu_sequencer.md
# wide_alu_sequencer

Multi-word arithmetic/logic sequencer that sits directly upstream of the 32-bit ALU stage. It accepts one wide operation (WORDS × 32 bits) over a valid/ready handshake and feeds it to the combinational ALU one 32-bit limb per cycle, least-significant first. It chains carry/borrow between limbs, assembles the wide result and returns it over a second valid/ready handshake.

## Interface
- WORDS, 2, number of 32-bit limbs per operand; legal range 1..4
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- op_valid  input  1  operation offered
- op_ready  output  1  sequencer can accept an operation
- op_a  input  32*WORDS  operand A
- op_b  input  32*WORDS  operand B
- op_cin  input  1  initial carry (ADD) or initial borrow (SUB)
- op_ctrl  input  2  00 ADD, 01 SUB, 10 OR, 11 AND
- alu_a  output  32  limb of A driven to the ALU
- alu_b  output  32  limb of B driven to the ALU
- alu_cin  output  1  carry/borrow driven to the ALU
- alu_ctrl  output  2  opcode driven to the ALU
- alu_out  input  32  ALU result for the current limb
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  32*WORDS  assembled result
- res_cout  output  1  final carry (ADD), final borrow (SUB), 0 for OR/AND

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - op_ready = 1.
  - On op_valid && op_ready: register op_a, op_b and op_ctrl.
  - Carry register <= op_cin for ADD/SUB, 0 for OR/AND.
  - Limb index <= 0; go to EXEC.
- EXEC:
  - Combinationally drive alu_a/alu_b = registered limb[index], alu_ctrl = registered ctrl, alu_cin = carry register (0 for OR/AND).
  - Each clock edge, capture alu_out into res_data limb[index].
  - Carry update is computed internally from the limb operands. alu_cout is not used for chaining.
    - ADD: carry = (alu_out < a_limb) || (carry && alu_out == a_limb).
    - SUB: borrow = (a_limb < b_limb) || (borrow && a_limb == b_limb).
    - OR/AND: 0.
  - Index increments.
  - After capturing limb WORDS-1, go to DONE.
- DONE:
  - res_valid = 1; res_cout = final carry register.
  - On res_ready, go to IDLE.
- op_ready = 1 only in IDLE and only while rst_n is high. No acceptance occurs in EXEC or DONE.
- Outside EXEC, alu_a, alu_b, alu_cin and alu_ctrl are 0.
- res_data and res_cout hold their last values after the result handshake until the next operation overwrites them limb by limb.
- All arithmetic is modulo 2^(32*WORDS). Limb-level wrap-around is handled solely by the carry chain.

## Timing
- Reset values (asynchronous, rst_n low):
  - State IDLE, res_valid 0, res_data 0, res_cout 0, carry 0, index 0.
  - alu_* outputs 0; op_ready 0 while rst_n is low.
- Latency: accept at edge T0. Limbs are captured at edges T0+1 .. T0+WORDS. res_valid is high after edge T0+WORDS.
- Throughput: one operation per WORDS+2 cycles with res_ready held high.
- The result handshake completes on the edge where res_valid && res_ready. res_valid deasserts after that edge.
- Backpressure: while res_ready is low in DONE, res_valid, res_data and res_cout are stable and op_ready stays 0.
- op_valid offered during EXEC or DONE is ignored. The source must hold it until the handshake.
- Reset asserted mid-EXEC or in DONE:
  - The operation is discarded with no partial result.
  - All outputs go to reset values immediately.
  - After release, the next operation behaves normally.
- WORDS=1: a single EXEC cycle; res_cout is the single-limb carry/borrow.

## Test plan
- ADD, WORDS=2, A=0x00000000_FFFFFFFF, B=0x1, cin=0 -> res_data=0x00000001_00000000, res_cout=0, res_valid exactly 2 edges after the accept edge.
- ADD, A=B=0xFFFFFFFF_FFFFFFFF, cin=1 -> res_data=0xFFFFFFFF_FFFFFFFF, res_cout=1.
- SUB:
  - 0x00000001_00000000 − 0x1, cin=0 -> 0x00000000_FFFFFFFF, res_cout=0.
  - 0x0 − 0x1 -> 0xFFFFFFFF_FFFFFFFF, res_cout=1.
  - Check alu_cin=1 on limb 1 of the first case.
- OR and AND:
  - A=0xF0F0F0F0_0000FFFF, B=0x0F0F0F0F_FFFF0000, cin=1 -> OR 0xFFFFFFFF_FFFFFFFF, AND 0x0, res_cout=0.
  - alu_cin stays 0 in both.
- Backpressure:
  - Hold res_ready low 5 cycles in DONE while op_valid is high with a new op.
  - Required: res_valid/res_data stable and op_ready=0 throughout.
  - The new op is accepted only in IDLE, after the result handshake.
- Drop rst_n during EXEC limb 0 of an ADD:
  - Required: res_valid=0, res_data=0, alu_* outputs 0 immediately.
  - After release, ADD 5+7 -> res_data=12, res_cout=0.
